// File: rtl/booth_ctrl_pkg.sv
// Shared constants for the radix-2 Booth sequencer: FSM encoding, Booth pair codes,
// the strobe bundle and its state/bit-pair decoder.
package booth_ctrl_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ARITH = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] BOOTH_SUB = 2'b10;
  localparam logic [1:0] BOOTH_ADD = 2'b01;

  typedef struct packed {
    logic carga_q;
    logic carga_m;
    logic clr_a;
    logic clr_qm1;
    logic carga_a;
    logic resta;
    logic desplaza_a;
    logic desplaza_q;
    logic desplaza_qm1;
    logic ocupado;
  } booth_strobes_t;

  // Only ARITH looks at the {q0,qm1} pair; every other state is a pure Moore decode.
  function automatic booth_strobes_t booth_decode(input logic [2:0] st, input logic [1:0] code);
    booth_strobes_t s;
    s = '0;
    case (st)
      S_LOAD: begin
        s.carga_q = 1'b1;
        s.carga_m = 1'b1;
        s.clr_a   = 1'b1;
        s.clr_qm1 = 1'b1;
        s.ocupado = 1'b1;
      end
      S_ARITH: begin
        s.ocupado = 1'b1;
        if (code == BOOTH_SUB) begin
          s.carga_a = 1'b1;
          s.resta   = 1'b1;
        end else if (code == BOOTH_ADD) begin
          s.carga_a = 1'b1;
        end else begin
          s.carga_a = 1'b0;
        end
      end
      S_SHIFT: begin
        s.desplaza_a   = 1'b1;
        s.desplaza_q   = 1'b1;
        s.desplaza_qm1 = 1'b1;
        s.ocupado      = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/booth_ctrl_iter_counter.sv
// Iteration down-counter for the Booth sequencer: loadable, decrements on enable,
// saturates at zero, flags the final iteration (count == 1).
module iter_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] count_r;

  // Iteration count register; never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign last = (count_r == CNT_ONE);

endmodule

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier sequencer: IDLE -> LOAD -> (ARITH -> SHIFT) x N -> DONE.
// Optional BOOTH_RESTART_EN: inicio in ARITH/SHIFT/DONE aborts and reloads.
module booth_ctrl
  import booth_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inicio,
  input  logic q0,
  input  logic qm1,
  output logic CargaQ,
  output logic CargaM,
  output logic ClrA,
  output logic ClrQm1,
  output logic CargaA,
  output logic Resta,
  output logic DesplazaA,
  output logic DesplazaQ,
  output logic DesplazaQm1,
  output logic Ocupado,
  output logic Fin
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);

  logic [2:0]     state_r;
  logic [2:0]     state_nxt_s;
  logic           last_s;
  logic           restart_s;
  logic           fin_r;
  booth_strobes_t strb_s;

`ifdef BOOTH_RESTART_EN
  assign restart_s = inicio;
`else
  assign restart_s = 1'b0;
`endif

  iter_counter #(.CNT_W(CNT_W)) u_iter_counter (
    .clk      (clk),
    .rst_n    (reset),
    .load     (state_r == S_LOAD),
    .load_val (CNT_LOAD),
    .dec      (state_r == S_SHIFT),
    .last     (last_s)
  );

  // Next-state logic.
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE:  state_nxt_s = inicio ? S_LOAD : S_IDLE;
      S_LOAD:  state_nxt_s = S_ARITH;
      S_ARITH: state_nxt_s = restart_s ? S_LOAD : S_SHIFT;
      S_SHIFT: begin
        if (restart_s) begin
          state_nxt_s = S_LOAD;
        end else if (last_s) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_ARITH;
        end
      end
      S_DONE:  state_nxt_s = restart_s ? S_LOAD : S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fin is sticky from DONE until the next LOAD; a restart out of DONE keeps it low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fin_r <= 1'b0;
    end else if (state_r == S_LOAD) begin
      fin_r <= 1'b0;
    end else if (state_r == S_DONE) begin
      fin_r <= !restart_s;
    end else begin
      fin_r <= fin_r;
    end
  end

  assign strb_s = booth_decode(state_r, {q0, qm1});

  assign CargaQ      = strb_s.carga_q;
  assign CargaM      = strb_s.carga_m;
  assign ClrA        = strb_s.clr_a;
  assign ClrQm1      = strb_s.clr_qm1;
  assign CargaA      = strb_s.carga_a;
  assign Resta       = strb_s.resta;
  assign DesplazaA   = strb_s.desplaza_a;
  assign DesplazaQ   = strb_s.desplaza_q;
  assign DesplazaQm1 = strb_s.desplaza_qm1;
  assign Ocupado     = strb_s.ocupado;
  assign Fin         = fin_r;

endmodule
